// File: rtl/button_mmio_port.sv
// Memory-mapped push-button and VGA output port for the processor data bus.
// Define BTN_PRESS_COUNT_EN to replace each sticky press flag with an 8-bit saturating press counter.
module button_mmio_port #(
    parameter logic [31:0] ADDR_BTNC = 32'd1000,
    parameter logic [31:0] ADDR_OUT  = 32'd2000,
    parameter logic [31:0] ADDR_BTNL = 32'd3000,
    parameter logic [31:0] ADDR_BTNR = 32'd4000,
    parameter logic [31:0] ADDR_BTNU = 32'd5000,
    parameter logic [31:0] ADDR_BTND = 32'd6000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  btn_in,
    input  logic [31:0] address_dmem,
    input  logic        wren,
    input  logic [31:0] data,
    input  logic [31:0] q_ram,
    output logic [31:0] q_dmem,
    output logic [31:0] out_data,
    output logic        out_valid
);

    // Index 0 is D (btn_in LSB) up to index 4 for C (btn_in MSB).
    localparam logic [31:0] BTN_ADDR [5] = '{ADDR_BTND, ADDR_BTNU, ADDR_BTNR, ADDR_BTNL, ADDR_BTNC};

    logic [4:0]  sync1_q, sync1_d;
    logic [4:0]  sync2_q, sync2_d;
    logic [4:0]  prev_q, prev_d;
    logic [2:0]  warm_q, warm_d;
    logic        sel_btn_q, sel_btn_d;
    logic [7:0]  rd_val_q, rd_val_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;

    logic [4:0]  rise;
    logic [4:0]  rd_hit;
    logic        wr_out;

`ifdef BTN_PRESS_COUNT_EN
    logic [7:0]  cnt_q [5];
    logic [7:0]  cnt_d [5];
`else
    logic [4:0]  pend_q, pend_d;
`endif

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        warm_d  = {warm_q[1:0], 1'b1};
        // prev_q only holds a real sample once warm_q[2] is set; this keeps a
        // button held through reset release from looking like a fresh press.
        rise    = sync2_q & ~prev_q & {5{warm_q[2]}};
    end

    always_comb begin
        rd_hit = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            rd_hit[i] = !wren && (address_dmem == BTN_ADDR[i]);
        end
        wr_out = wren && (address_dmem == ADDR_OUT);
    end

`ifdef BTN_PRESS_COUNT_EN
    always_comb begin
        rd_val_d = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
            if (rd_hit[i]) begin
                rd_val_d = cnt_q[i];
                cnt_d[i] = rise[i] ? 8'd1 : 8'd0;
            end else if (rise[i] && cnt_q[i] != 8'hFF) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end
`else
    always_comb begin
        rd_val_d = '0;
        pend_d   = pend_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (rd_hit[i]) begin
                rd_val_d  = {7'b0, pend_q[i]};
                pend_d[i] = 1'b0;
            end
            // A coincident edge wins over the clear, so the press is kept.
            if (rise[i]) begin
                pend_d[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_btn_d   = |rd_hit;
        out_valid_d = wr_out;
        out_data_d  = wr_out ? data : out_data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            warm_q      <= '0;
            sel_btn_q   <= 1'b0;
            rd_val_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            warm_q      <= warm_d;
            sel_btn_q   <= sel_btn_d;
            rd_val_q    <= rd_val_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef BTN_PRESS_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    assign q_dmem    = sel_btn_q ? {24'b0, rd_val_q} : q_ram;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
